// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and stall controller for the 5-stage MIPS pipeline.
// Define DEBUG_STEP_EN to add the debug_en/debug_step single-step hold.
module pipe_hazard_unit #(
    parameter int ADDR_W     = 5,
    parameter int NUM_SRC    = 2,
    parameter int LAT_W      = 4,
    parameter int CNT_W      = 16,
    parameter int DELAY_SLOT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic                      id_is_store,
    input  logic                      id_mc_start,
    input  logic [LAT_W-1:0]          id_mc_lat,
    input  logic                      branch_taken,
    input  logic                      exe_wen,
    input  logic                      exe_is_load,
    input  logic [ADDR_W-1:0]         exe_waddr,
    input  logic                      mem_wen,
    input  logic                      mem_is_load,
    input  logic                      mem_is_store,
    input  logic [ADDR_W-1:0]         mem_waddr,
    input  logic [ADDR_W-1:0]         mem_rt_addr,
    input  logic                      wb_wen,
    input  logic [ADDR_W-1:0]         wb_waddr,
`ifdef DEBUG_STEP_EN
    input  logic                      debug_en,
    input  logic                      debug_step,
`endif
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      fwd_mem,
    output logic                      if_en,
    output logic                      id_en,
    output logic                      exe_en,
    output logic                      mem_en,
    output logic                      wb_en,
    output logic                      if_rst,
    output logic                      id_rst,
    output logic                      exe_rst,
    output logic                      mem_rst,
    output logic                      wb_rst,
    output logic                      mc_busy,
    output logic [CNT_W-1:0]          stall_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mc_state_t;

    localparam logic FLUSH_EN = (DELAY_SLOT == 32'sd0);

    mc_state_t              state_r;
    logic [LAT_W-1:0]       mc_cnt_r;
    logic                   mc_busy_r;
    logic [CNT_W-1:0]       stall_cnt_r;
    logic [2*NUM_SRC-1:0]   fwd_sel_s;
    logic                   fwd_mem_s;
    logic                   load_stall_s;
    logic                   hold_s;
    logic                   busy_s;
    logic                   mc_go_s;
    logic                   id_stall_s;

`ifdef DEBUG_STEP_EN
    logic debug_step_r;

    // Previous debug_step level, for single-step rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            debug_step_r <= 1'b0;
        end else begin
            debug_step_r <= debug_step;
        end
    end

    assign hold_s = debug_en & ~(debug_step & ~debug_step_r);
`else
    assign hold_s = 1'b0;
`endif

    assign busy_s     = (state_r == ST_BUSY);
    assign mc_go_s    = ~hold_s & ~busy_s & ~load_stall_s & id_mc_start
                        & (id_mc_lat >= LAT_W'(2'd2));
    assign id_stall_s = ~hold_s & (busy_s | load_stall_s);
    assign fwd_mem_s  = mem_is_store & (mem_rt_addr != {ADDR_W{1'b0}}) & wb_wen
                        & (wb_waddr == mem_rt_addr);

    // Per-source operand match against EXE and MEM destinations; EXE wins
    always_comb begin
        fwd_sel_s    = {(2*NUM_SRC){1'b0}};
        load_stall_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used[i] && !id_is_store &&
                (id_src_addr[i*ADDR_W +: ADDR_W] != {ADDR_W{1'b0}})) begin
                if (exe_wen && (exe_waddr == id_src_addr[i*ADDR_W +: ADDR_W])) begin
                    if (exe_is_load) begin
                        load_stall_s = 1'b1;
                    end else begin
                        fwd_sel_s[2*i +: 2] = 2'd1;
                    end
                end else if (mem_wen && (mem_waddr == id_src_addr[i*ADDR_W +: ADDR_W])) begin
                    if (mem_is_load) begin
                        fwd_sel_s[2*i +: 2] = 2'd3;
                    end else begin
                        fwd_sel_s[2*i +: 2] = 2'd2;
                    end
                end else begin
                    fwd_sel_s[2*i +: 2] = 2'd0;
                end
            end else begin
                fwd_sel_s[2*i +: 2] = 2'd0;
            end
        end
    end

    // Stage enable/clear resolution in priority order
    always_comb begin
        if_en   = 1'b1;
        id_en   = 1'b1;
        exe_en  = 1'b1;
        mem_en  = 1'b1;
        wb_en   = 1'b1;
        if_rst  = 1'b0;
        id_rst  = 1'b0;
        exe_rst = 1'b0;
        mem_rst = 1'b0;
        wb_rst  = 1'b0;
        fwd_sel = fwd_sel_s;
        fwd_mem = fwd_mem_s;
        if (rst) begin
            if_rst  = 1'b1;
            id_rst  = 1'b1;
            exe_rst = 1'b1;
            mem_rst = 1'b1;
            wb_rst  = 1'b1;
            fwd_sel = {(2*NUM_SRC){1'b0}};
            fwd_mem = 1'b0;
        end else if (hold_s) begin
            if_en  = 1'b0;
            id_en  = 1'b0;
            exe_en = 1'b0;
            mem_en = 1'b0;
            wb_en  = 1'b0;
        end else if (busy_s) begin
            if_en   = 1'b0;
            id_en   = 1'b0;
            exe_en  = 1'b0;
            mem_rst = 1'b1;
        end else if (load_stall_s) begin
            if_en   = 1'b0;
            id_en   = 1'b0;
            exe_rst = 1'b1;
        end else if (FLUSH_EN && branch_taken) begin
            id_rst = 1'b1;
        end else begin
            id_rst = 1'b0;
        end
    end

    // Multi-cycle occupancy FSM; counter holds remaining EXE cycles after the first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            mc_cnt_r  <= {LAT_W{1'b0}};
            mc_busy_r <= 1'b0;
        end else if (hold_s) begin
            state_r   <= state_r;
            mc_cnt_r  <= mc_cnt_r;
            mc_busy_r <= mc_busy_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mc_go_s) begin
                        state_r   <= ST_BUSY;
                        mc_cnt_r  <= id_mc_lat - LAT_W'(1'b1);
                        mc_busy_r <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        mc_cnt_r  <= {LAT_W{1'b0}};
                        mc_busy_r <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (mc_cnt_r <= LAT_W'(1'b1)) begin
                        state_r   <= ST_IDLE;
                        mc_cnt_r  <= {LAT_W{1'b0}};
                        mc_busy_r <= 1'b0;
                    end else begin
                        state_r   <= ST_BUSY;
                        mc_cnt_r  <= mc_cnt_r - LAT_W'(1'b1);
                        mc_busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mc_cnt_r  <= {LAT_W{1'b0}};
                    mc_busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of ID stall cycles; frozen while the debugger holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (id_stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign mc_busy   = mc_busy_r & ~rst;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed scenarios plus random
// traffic against a cycle-level model; flush and delay-slot builds run side by side.
module tb_pipe_hazard_unit;
    localparam int AW = 5;
    localparam int NS = 2;
    localparam int LW = 4;
    localparam int CW = 16;
    localparam logic [9:0] C_RUN   = 10'b11111_00000;
    localparam logic [9:0] C_BUSY  = 10'b00011_00010;
    localparam logic [9:0] C_LOAD  = 10'b00111_00100;
    localparam logic [9:0] C_FLUSH = 10'b11111_01000;
    localparam logic [9:0] C_RST   = 10'b11111_11111;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NS*AW-1:0] id_src_addr;
    logic [NS-1:0]    id_src_used;
    logic id_is_store, id_mc_start, branch_taken;
    logic [LW-1:0] id_mc_lat;
    logic exe_wen, exe_is_load, mem_wen, mem_is_load, mem_is_store, wb_wen;
    logic [AW-1:0] exe_waddr, mem_waddr, mem_rt_addr, wb_waddr;
`ifdef DEBUG_STEP_EN
    logic debug_en = 1'b0;
    logic debug_step = 1'b0;
`endif
    logic [2*NS-1:0] fwd_sel, d1_fwd_sel;
    logic fwd_mem, d1_fwd_mem, mc_busy, d1_mc_busy;
    logic if_en, id_en, exe_en, mem_en, wb_en, if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic d1_if_en, d1_id_en, d1_exe_en, d1_mem_en, d1_wb_en;
    logic d1_if_rst, d1_id_rst, d1_exe_rst, d1_mem_rst, d1_wb_rst;
    logic [CW-1:0] stall_cnt, d1_stall_cnt;
    logic [9:0] ctrl0, ctrl1;

    assign ctrl0 = {if_en, id_en, exe_en, mem_en, wb_en, if_rst, id_rst, exe_rst, mem_rst, wb_rst};
    assign ctrl1 = {d1_if_en, d1_id_en, d1_exe_en, d1_mem_en, d1_wb_en,
                    d1_if_rst, d1_id_rst, d1_exe_rst, d1_mem_rst, d1_wb_rst};

    pipe_hazard_unit #(.ADDR_W(AW), .NUM_SRC(NS), .LAT_W(LW), .CNT_W(CW), .DELAY_SLOT(0)) dut (
        .clk(clk), .rst(rst), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
        .id_is_store(id_is_store), .id_mc_start(id_mc_start), .id_mc_lat(id_mc_lat),
        .branch_taken(branch_taken), .exe_wen(exe_wen), .exe_is_load(exe_is_load),
        .exe_waddr(exe_waddr), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
        .mem_is_store(mem_is_store), .mem_waddr(mem_waddr), .mem_rt_addr(mem_rt_addr),
        .wb_wen(wb_wen), .wb_waddr(wb_waddr),
`ifdef DEBUG_STEP_EN
        .debug_en(debug_en), .debug_step(debug_step),
`endif
        .fwd_sel(fwd_sel), .fwd_mem(fwd_mem), .if_en(if_en), .id_en(id_en), .exe_en(exe_en),
        .mem_en(mem_en), .wb_en(wb_en), .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst),
        .mem_rst(mem_rst), .wb_rst(wb_rst), .mc_busy(mc_busy), .stall_cnt(stall_cnt)
    );

    pipe_hazard_unit #(.ADDR_W(AW), .NUM_SRC(NS), .LAT_W(LW), .CNT_W(CW), .DELAY_SLOT(1)) dut_ds (
        .clk(clk), .rst(rst), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
        .id_is_store(id_is_store), .id_mc_start(id_mc_start), .id_mc_lat(id_mc_lat),
        .branch_taken(branch_taken), .exe_wen(exe_wen), .exe_is_load(exe_is_load),
        .exe_waddr(exe_waddr), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
        .mem_is_store(mem_is_store), .mem_waddr(mem_waddr), .mem_rt_addr(mem_rt_addr),
        .wb_wen(wb_wen), .wb_waddr(wb_waddr),
`ifdef DEBUG_STEP_EN
        .debug_en(debug_en), .debug_step(debug_step),
`endif
        .fwd_sel(d1_fwd_sel), .fwd_mem(d1_fwd_mem), .if_en(d1_if_en), .id_en(d1_id_en),
        .exe_en(d1_exe_en), .mem_en(d1_mem_en), .wb_en(d1_wb_en), .if_rst(d1_if_rst),
        .id_rst(d1_id_rst), .exe_rst(d1_exe_rst), .mem_rst(d1_mem_rst), .wb_rst(d1_wb_rst),
        .mc_busy(d1_mc_busy), .stall_cnt(d1_stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int m_busy_left = 0;
    int m_stall = 0;
    bit m_ls;
    logic [2*NS-1:0] exp_fwd;
    logic exp_fwd_mem, exp_busy;
    logic [9:0] exp_ctrl0, exp_ctrl1;

    // Reference model: expected outputs for the current inputs and model state
    task automatic model_eval();
        logic [AW-1:0] a;
        bit busy;
        m_ls = 1'b0;
        exp_fwd = '0;
        for (int i = 0; i < NS; i++) begin
            a = id_src_addr[i*AW +: AW];
            if (id_src_used[i] && a != 0 && !id_is_store) begin
                if (exe_wen && exe_waddr == a) begin
                    if (exe_is_load) m_ls = 1'b1;
                    else exp_fwd[2*i +: 2] = 2'd1;
                end else if (mem_wen && mem_waddr == a) begin
                    exp_fwd[2*i +: 2] = mem_is_load ? 2'd3 : 2'd2;
                end
            end
        end
        exp_fwd_mem = mem_is_store && mem_rt_addr != 0 && wb_wen && wb_waddr == mem_rt_addr;
        busy = (m_busy_left > 0);
        exp_busy = busy;
        exp_ctrl0 = busy ? C_BUSY : (m_ls ? C_LOAD : (branch_taken ? C_FLUSH : C_RUN));
        exp_ctrl1 = busy ? C_BUSY : (m_ls ? C_LOAD : C_RUN);
    endtask

    task automatic model_advance();
        model_eval();
        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_stall < 65535) m_stall++;
        end else if (m_ls) begin
            if (m_stall < 65535) m_stall++;
        end else if (id_mc_start && id_mc_lat >= 2) begin
            m_busy_left = int'(id_mc_lat) - 1;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic set_idle();
        id_src_addr = '0; id_src_used = '0; id_is_store = 1'b0;
        id_mc_start = 1'b0; id_mc_lat = '0; branch_taken = 1'b0;
        exe_wen = 1'b0; exe_is_load = 1'b0; exe_waddr = '0;
        mem_wen = 1'b0; mem_is_load = 1'b0; mem_is_store = 1'b0;
        mem_waddr = '0; mem_rt_addr = '0; wb_wen = 1'b0; wb_waddr = '0;
    endtask

    task automatic test_reset();
        set_idle();
        exe_wen = 1'b1; exe_waddr = 5'd5; id_src_addr = {5'd0, 5'd5}; id_src_used = 2'b01;
        mem_is_store = 1'b1; mem_rt_addr = 5'd7; wb_wen = 1'b1; wb_waddr = 5'd7;
        #2 rst = 1'b1;
        @(negedge clk); @(negedge clk);
        n_checks++; if (ctrl0 !== C_RST) begin n_fail++; $display("FAIL rst_ctrl got=%b exp=%b", ctrl0, C_RST); end
        n_checks++; if (fwd_sel !== 4'd0) begin n_fail++; $display("FAIL rst_fwd_sel got=%0d exp=0", fwd_sel); end
        n_checks++; if (fwd_mem !== 1'b0) begin n_fail++; $display("FAIL rst_fwd_mem got=%b exp=0", fwd_mem); end
        n_checks++; if (mc_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mc_busy got=%b exp=0", mc_busy); end
        n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
        @(posedge clk); #1;
        rst = 1'b0; m_busy_left = 0; m_stall = 0;
        set_idle();
        tick();
    endtask

    task automatic test_forward();
        set_idle();
        exe_wen = 1'b1; exe_waddr = 5'd5;
        mem_wen = 1'b1; mem_waddr = 5'd6;
        id_src_addr = {5'd6, 5'd5}; id_src_used = 2'b11;
        sample();
        n_checks++; if (fwd_sel !== 4'b1001) begin n_fail++; $display("FAIL fwd_exe_mem got=%b exp=1001", fwd_sel); end
        n_checks++; if (ctrl0 !== C_RUN) begin n_fail++; $display("FAIL fwd_no_stall got=%b exp=%b", ctrl0, C_RUN); end
        tick();
        mem_waddr = 5'd5; mem_is_load = 1'b1; id_src_addr = {5'd5, 5'd5};
        sample();
        n_checks++; if (fwd_sel !== 4'b0101) begin n_fail++; $display("FAIL fwd_exe_priority got=%b exp=0101", fwd_sel); end
        tick();
        exe_waddr = 5'd0; mem_waddr = 5'd0; id_src_addr = {5'd0, 5'd0};
        sample();
        n_checks++; if (fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL fwd_r0 got=%b exp=0000", fwd_sel); end
        tick();
        exe_waddr = 5'd9; exe_is_load = 1'b1; id_src_addr = {5'd9, 5'd9}; id_is_store = 1'b1;
        sample();
        n_checks++; if (ctrl0 !== C_RUN || fwd_sel !== 4'd0) begin n_fail++; $display("FAIL fwd_store_ignored ctrl=%b fwd=%b exp ctrl=%b fwd=0", ctrl0, fwd_sel, C_RUN); end
        tick();
    endtask

    task automatic test_load_use();
        int s0;
        set_idle();
        s0 = m_stall;
        exe_wen = 1'b1; exe_is_load = 1'b1; exe_waddr = 5'd5;
        id_src_addr = {5'd5, 5'd2}; id_src_used = 2'b10;
        sample();
        n_checks++; if (ctrl0 !== C_LOAD) begin n_fail++; $display("FAIL load_stall got=%b exp=%b", ctrl0, C_LOAD); end
        tick();
        exe_wen = 1'b0; exe_is_load = 1'b0;
        mem_wen = 1'b1; mem_is_load = 1'b1; mem_waddr = 5'd5;
        sample();
        n_checks++; if (fwd_sel[3:2] !== 2'd3) begin n_fail++; $display("FAIL load_fwd got=%0d exp=3", fwd_sel[3:2]); end
        n_checks++; if (ctrl0 !== C_RUN) begin n_fail++; $display("FAIL load_one_bubble got=%b exp=%b", ctrl0, C_RUN); end
        n_checks++; if (stall_cnt !== 16'(s0 + 1)) begin n_fail++; $display("FAIL load_stall_cnt got=%0d exp=%0d", stall_cnt, s0 + 1); end
        tick();
    endtask

    task automatic test_multicycle();
        int s0;
        set_idle();
        s0 = m_stall;
        id_mc_start = 1'b1; id_mc_lat = 4'd4;
        sample();
        n_checks++; if (mc_busy !== 1'b0 || ctrl0 !== C_RUN) begin n_fail++; $display("FAIL mc_start_cycle busy=%b ctrl=%b exp busy=0 ctrl=%b", mc_busy, ctrl0, C_RUN); end
        tick();
        set_idle();
        for (int k = 0; k < 3; k++) begin
            sample();
            n_checks++; if (mc_busy !== 1'b1 || ctrl0 !== C_BUSY) begin n_fail++; $display("FAIL mc_busy_cycle%0d busy=%b ctrl=%b exp busy=1 ctrl=%b", k, mc_busy, ctrl0, C_BUSY); end
            tick();
        end
        sample();
        n_checks++; if (mc_busy !== 1'b0 || ctrl0 !== C_RUN) begin n_fail++; $display("FAIL mc_done busy=%b ctrl=%b exp busy=0 ctrl=%b", mc_busy, ctrl0, C_RUN); end
        n_checks++; if (stall_cnt !== 16'(s0 + 3)) begin n_fail++; $display("FAIL mc_stall_cnt got=%0d exp=%0d", stall_cnt, s0 + 3); end
        tick();
        id_mc_start = 1'b1; id_mc_lat = 4'd1;
        tick();
        set_idle();
        sample();
        n_checks++; if (mc_busy !== 1'b0 || ctrl0 !== C_RUN) begin n_fail++; $display("FAIL mc_lat1 busy=%b ctrl=%b exp busy=0 ctrl=%b", mc_busy, ctrl0, C_RUN); end
        tick();
    endtask

    task automatic test_branch();
        set_idle();
        branch_taken = 1'b1;
        sample();
        n_checks++; if (ctrl0 !== C_FLUSH) begin n_fail++; $display("FAIL br_flush got=%b exp=%b", ctrl0, C_FLUSH); end
        n_checks++; if (ctrl1 !== C_RUN) begin n_fail++; $display("FAIL br_delay_slot got=%b exp=%b", ctrl1, C_RUN); end
        tick();
        exe_wen = 1'b1; exe_is_load = 1'b1; exe_waddr = 5'd3;
        id_src_addr = {5'd0, 5'd3}; id_src_used = 2'b01;
        sample();
        n_checks++; if (ctrl0 !== C_LOAD) begin n_fail++; $display("FAIL br_under_load got=%b exp=%b", ctrl0, C_LOAD); end
        tick();
        set_idle();
        tick();
    endtask

    task automatic test_store_fwd();
        set_idle();
        mem_is_store = 1'b1; mem_rt_addr = 5'd7; wb_wen = 1'b1; wb_waddr = 5'd7;
        sample();
        n_checks++; if (fwd_mem !== 1'b1) begin n_fail++; $display("FAIL st_fwd_r7 got=%b exp=1", fwd_mem); end
        tick();
        mem_rt_addr = 5'd0; wb_waddr = 5'd0;
        sample();
        n_checks++; if (fwd_mem !== 1'b0) begin n_fail++; $display("FAIL st_fwd_r0 got=%b exp=0", fwd_mem); end
        tick();
        mem_rt_addr = 5'd7; wb_waddr = 5'd7; wb_wen = 1'b0;
        sample();
        n_checks++; if (fwd_mem !== 1'b0) begin n_fail++; $display("FAIL st_fwd_nowen got=%b exp=0", fwd_mem); end
        tick();
    endtask

    task automatic test_reset_busy();
        set_idle();
        id_mc_start = 1'b1; id_mc_lat = 4'd5;
        tick();
        set_idle();
        tick();
        tick();
        exe_wen = 1'b1; exe_waddr = 5'd4; id_src_addr = {5'd0, 5'd4}; id_src_used = 2'b01;
        rst = 1'b1;
        #1;
        n_checks++; if (mc_busy !== 1'b0) begin n_fail++; $display("FAIL rstb_mc_busy got=%b exp=0", mc_busy); end
        n_checks++; if (ctrl0 !== C_RST) begin n_fail++; $display("FAIL rstb_ctrl got=%b exp=%b", ctrl0, C_RST); end
        n_checks++; if (stall_cnt !== 16'd0 || fwd_sel !== 4'd0) begin n_fail++; $display("FAIL rstb_cnt_fwd cnt=%0d fwd=%0d exp 0 0", stall_cnt, fwd_sel); end
        m_busy_left = 0; m_stall = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        set_idle();
        sample();
        n_checks++; if (mc_busy !== 1'b0 || ctrl0 !== C_RUN) begin n_fail++; $display("FAIL rstb_after busy=%b ctrl=%b exp busy=0 ctrl=%b", mc_busy, ctrl0, C_RUN); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NS; i++) id_src_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
            id_src_used  = NS'($urandom);
            id_is_store  = ($urandom_range(0, 7) == 0);
            id_mc_start  = ($urandom_range(0, 4) == 0);
            id_mc_lat    = LW'($urandom_range(0, 6));
            branch_taken = ($urandom_range(0, 3) == 0);
            exe_wen = 1'($urandom); exe_is_load = 1'($urandom); exe_waddr = AW'($urandom_range(0, 3));
            mem_wen = 1'($urandom); mem_is_load = 1'($urandom); mem_is_store = 1'($urandom);
            mem_waddr = AW'($urandom_range(0, 3)); mem_rt_addr = AW'($urandom_range(0, 3));
            wb_wen = 1'($urandom); wb_waddr = AW'($urandom_range(0, 3));
            sample();
            n_checks++; if (ctrl0 !== exp_ctrl0) begin n_fail++; $display("FAIL rnd_ctrl c=%0d got=%b exp=%b", c, ctrl0, exp_ctrl0); end
            n_checks++; if (ctrl1 !== exp_ctrl1) begin n_fail++; $display("FAIL rnd_ctrl_ds c=%0d got=%b exp=%b", c, ctrl1, exp_ctrl1); end
            n_checks++; if (fwd_sel !== exp_fwd) begin n_fail++; $display("FAIL rnd_fwd_sel c=%0d got=%b exp=%b", c, fwd_sel, exp_fwd); end
            n_checks++; if (fwd_mem !== exp_fwd_mem) begin n_fail++; $display("FAIL rnd_fwd_mem c=%0d got=%b exp=%b", c, fwd_mem, exp_fwd_mem); end
            n_checks++; if (mc_busy !== exp_busy) begin n_fail++; $display("FAIL rnd_mc_busy c=%0d got=%b exp=%b", c, mc_busy, exp_busy); end
            n_checks++; if (stall_cnt !== 16'(m_stall)) begin n_fail++; $display("FAIL rnd_stall_cnt c=%0d got=%0d exp=%0d", c, stall_cnt, m_stall); end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_multicycle();
        test_branch();
        test_store_fwd();
        test_reset_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
